// File: rtl/gb_interposer_if.sv
// Host-side and child-side ghostbus signals of one interposer segment.
// The master modport is the parent/bench view; slave is the interposer's view.
interface gb_interposer_if #(
   parameter int unsigned AW    = 24,
   parameter int unsigned DW    = 32,
   parameter int unsigned NCHAN = 2,
   parameter int unsigned CAW   = 22
) ();
   logic [AW-1:0]       host_addr;
   logic [DW-1:0]       host_wdata;
   logic                host_we;
   logic                host_re;
   logic [DW-1:0]       host_rdata;
   logic                host_rvalid;
   logic [CAW-1:0]      ch_addr;
   logic [DW-1:0]       ch_wdata;
   logic [NCHAN-1:0]    ch_we;
   logic [NCHAN-1:0]    ch_re;
   logic [NCHAN*DW-1:0] ch_rdata;

   modport master (
      output host_addr, host_wdata, host_we, host_re,
      input  host_rdata, host_rvalid,
      input  ch_addr, ch_wdata, ch_we, ch_re,
      output ch_rdata
   );

   modport slave (
      input  host_addr, host_wdata, host_we, host_re,
      output host_rdata, host_rvalid,
      output ch_addr, ch_wdata, ch_we, ch_re,
      input  ch_rdata
   );
endinterface

// File: rtl/gb_interposer.sv
// Ghostbus interposer: fans one host port out to NCHAN windows of 2^CAW words,
// with optional registered child stage, in-order read return and OOB tracking.
module gb_interposer #(
   parameter int unsigned AW       = 24,
   parameter int unsigned DW       = 32,
   parameter int unsigned NCHAN    = 2,
   parameter int unsigned CAW      = 22,
   parameter int unsigned PIPE     = 1,
   parameter int unsigned RD_LAT   = 1,
   parameter logic [31:0] OOB_DATA = 32'hDEADBEEF
) (
   input  logic          clk,
   input  logic          rst_n,
   gb_interposer_if.slave bus,
   input  logic          err_clr,
   output logic          err_oob,
   output logic [AW-1:0] err_addr
);
   localparam int unsigned SELW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int unsigned L    = PIPE + RD_LAT;

   if ((NCHAN < 1) || (NCHAN > 16) || (PIPE > 1) || (RD_LAT > 4) ||
       (CAW + $clog2(NCHAN) > AW)) begin : g_bad_cfg
      $error("gb_interposer: illegal parameter combination");
   end

   // Zero-extended so the select slice stays legal even when CAW+SELW > AW.
   logic [AW+SELW-1:0] w_addr_ext;
   logic [SELW-1:0]    w_sel;
   logic               w_inr, w_wr, w_rd, w_acc;
   logic [NCHAN-1:0]   w_onehot, w_we_n, w_re_n;

   assign w_addr_ext = {{SELW{1'b0}}, bus.host_addr};
   assign w_sel      = w_addr_ext[CAW +: SELW];
   assign w_inr      = ((w_addr_ext >> (CAW + SELW)) == '0) && (32'(w_sel) < NCHAN);
   assign w_wr       = bus.host_we;
   assign w_rd       = bus.host_re & ~bus.host_we;
   assign w_acc      = w_wr | w_rd;
   assign w_onehot   = NCHAN'(1) << w_sel;
   assign w_we_n     = (w_wr && w_inr) ? w_onehot : '0;
   assign w_re_n     = (w_rd && w_inr) ? w_onehot : '0;

   if (PIPE == 1) begin : g_pipe
      logic [NCHAN-1:0] r_ch_we, r_ch_re;
      logic [CAW-1:0]   r_ch_addr;
      logic [DW-1:0]    r_ch_wdata;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ch_we    <= '0;
            r_ch_re    <= '0;
            r_ch_addr  <= '0;
            r_ch_wdata <= '0;
         end else begin
            r_ch_we <= w_we_n;
            r_ch_re <= w_re_n;
            if (w_acc) begin
               r_ch_addr  <= bus.host_addr[CAW-1:0];
               r_ch_wdata <= bus.host_wdata;
            end
         end
      end

      assign bus.ch_we    = r_ch_we;
      assign bus.ch_re    = r_ch_re;
      assign bus.ch_addr  = r_ch_addr;
      assign bus.ch_wdata = r_ch_wdata;
   end else begin : g_comb
      assign bus.ch_we    = rst_n ? w_we_n : '0;
      assign bus.ch_re    = rst_n ? w_re_n : '0;
      assign bus.ch_addr  = rst_n ? bus.host_addr[CAW-1:0] : '0;
      assign bus.ch_wdata = rst_n ? bus.host_wdata : '0;
   end

   // Tail of the read tracker: the entry whose data is captured this cycle.
   logic            w_tv, w_toob;
   logic [SELW-1:0] w_tsel;
   logic [DW-1:0]   w_tdata;

   if (L >= 2) begin : g_trk
      logic [L-2:0]    r_tv, r_toob;
      logic [SELW-1:0] r_tsel [L-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_tv   <= '0;
            r_toob <= '0;
            for (int i = 0; i < L - 1; i++) r_tsel[i] <= '0;
         end else begin
            r_tv[0]   <= w_rd;
            r_toob[0] <= ~w_inr;
            r_tsel[0] <= w_sel;
            for (int i = 1; i < L - 1; i++) begin
               r_tv[i]   <= r_tv[i-1];
               r_toob[i] <= r_toob[i-1];
               r_tsel[i] <= r_tsel[i-1];
            end
         end
      end

      assign w_tv   = r_tv[L-2];
      assign w_toob = r_toob[L-2];
      assign w_tsel = r_tsel[L-2];
   end else begin : g_trk0
      assign w_tv   = w_rd;
      assign w_toob = ~w_inr;
      assign w_tsel = w_sel;
   end

   always_comb begin
      w_tdata = DW'(OOB_DATA);
      if (!w_toob) begin
         w_tdata = '0;
         for (int k = 0; k < NCHAN; k++) begin
            if (w_tsel == SELW'(k)) w_tdata = bus.ch_rdata[k*DW +: DW];
         end
      end
   end

   logic [DW-1:0] r_rdata;

   if (L > 0) begin : g_ret_reg
      logic r_rvalid;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
         end else begin
            r_rvalid <= w_tv;
            if (w_tv) r_rdata <= w_tdata;
         end
      end

      assign bus.host_rvalid = r_rvalid;
      assign bus.host_rdata  = r_rdata;
   end else begin : g_ret_comb
      // Holds the last returned word so host_rdata is stable between returns.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    r_rdata <= '0;
         else if (w_tv) r_rdata <= w_tdata;
      end

      assign bus.host_rvalid = rst_n & w_tv;
      assign bus.host_rdata  = !rst_n ? '0 : (w_tv ? w_tdata : r_rdata);
   end

   logic          r_err_oob;
   logic [AW-1:0] r_err_addr;

   // A new out-of-range access wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_oob  <= 1'b0;
         r_err_addr <= '0;
      end else if (w_acc && !w_inr) begin
         r_err_oob  <= 1'b1;
         r_err_addr <= bus.host_addr;
      end else if (err_clr) begin
         r_err_oob  <= 1'b0;
      end
   end

   assign err_oob  = r_err_oob;
   assign err_addr = r_err_addr;
endmodule

// File: tb/tb_gb_interposer.sv
// Bench for gb_interposer: a pipelined (PIPE=1, RD_LAT=1) and a combinational
// (PIPE=0, RD_LAT=0) instance driven in lockstep against a behavioural model.
module tb_gb_interposer;
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned NCHAN = 3;
   localparam int unsigned CAW   = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0]  t_addr;
   logic [31:0] t_wdata;
   logic        t_we, t_re, t_clr;
   logic        err_oob_p, err_oob_c;
   logic [7:0]  err_addr_p, err_addr_c;

   gb_interposer_if #(.AW(AW), .DW(DW), .NCHAN(NCHAN), .CAW(CAW)) bus_p ();
   gb_interposer_if #(.AW(AW), .DW(DW), .NCHAN(NCHAN), .CAW(CAW)) bus_c ();

   assign bus_p.host_addr  = t_addr;
   assign bus_p.host_wdata = t_wdata;
   assign bus_p.host_we    = t_we;
   assign bus_p.host_re    = t_re;
   assign bus_p.ch_rdata   = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
   assign bus_c.host_addr  = t_addr;
   assign bus_c.host_wdata = t_wdata;
   assign bus_c.host_we    = t_we;
   assign bus_c.host_re    = t_re;
   assign bus_c.ch_rdata   = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

   gb_interposer #(
      .AW(AW), .DW(DW), .NCHAN(NCHAN), .CAW(CAW), .PIPE(1), .RD_LAT(1),
      .OOB_DATA(32'hDEADBEEF)
   ) u_dut_p (
      .clk(clk), .rst_n(rst_n), .bus(bus_p), .err_clr(t_clr),
      .err_oob(err_oob_p), .err_addr(err_addr_p)
   );

   gb_interposer #(
      .AW(AW), .DW(DW), .NCHAN(NCHAN), .CAW(CAW), .PIPE(0), .RD_LAT(0),
      .OOB_DATA(32'hDEADBEEF)
   ) u_dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c), .err_clr(t_clr),
      .err_oob(err_oob_c), .err_addr(err_addr_c)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Address map: channel k owns 16*k .. 16*k+15; everything from 0x30 up is out of range.
   function automatic logic in_range(input logic [7:0] a);
      return a < 8'd48;
   endfunction

   function automatic logic [2:0] chan_bit(input logic [7:0] a);
      return in_range(a) ? 3'(1 << (a / 16)) : 3'b000;
   endfunction

   function automatic logic [31:0] data_of(input logic [7:0] a);
      return in_range(a) ? (32'hC0DE0000 + 32'(a / 16)) : 32'hDEADBEEF;
   endfunction

   typedef struct {int due; logic [31:0] data;} ret_t;
   ret_t        q[$];
   int          cyc;
   logic [2:0]  m_we_p, m_re_p;
   logic [3:0]  m_addr_p;
   logic [31:0] m_wdata_p, m_rdata_p, m_rdata_c;
   logic        m_err;
   logic [7:0]  m_eaddr;

   task automatic model_reset();
      q.delete();
      m_we_p = '0; m_re_p = '0; m_addr_p = '0; m_wdata_p = '0;
      m_rdata_p = '0; m_rdata_c = '0; m_err = 1'b0; m_eaddr = '0;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, " p.ch_we"}, bus_p.ch_we, 0);
      check_val({tag, " p.ch_re"}, bus_p.ch_re, 0);
      check_val({tag, " p.ch_addr"}, bus_p.ch_addr, 0);
      check_val({tag, " p.ch_wdata"}, bus_p.ch_wdata, 0);
      check_val({tag, " p.rvalid"}, bus_p.host_rvalid, 0);
      check_val({tag, " p.rdata"}, bus_p.host_rdata, 0);
      check_val({tag, " p.err_oob"}, err_oob_p, 0);
      check_val({tag, " p.err_addr"}, err_addr_p, 0);
      check_val({tag, " c.ch_we"}, bus_c.ch_we, 0);
      check_val({tag, " c.ch_re"}, bus_c.ch_re, 0);
      check_val({tag, " c.ch_addr"}, bus_c.ch_addr, 0);
      check_val({tag, " c.rvalid"}, bus_c.host_rvalid, 0);
      check_val({tag, " c.rdata"}, bus_c.host_rdata, 0);
      check_val({tag, " c.err_oob"}, err_oob_c, 0);
   endtask

   // Drives one cycle of host activity, checks both DUTs mid-cycle, then advances the model.
   task automatic run_cycle(input logic [7:0] a, input logic [31:0] d,
                            input logic we, input logic re, input logic clr);
      logic        rd, rv_p;
      logic [31:0] rdat_p;
      t_addr = a; t_wdata = d; t_we = we; t_re = re; t_clr = clr;
      rd = re && !we;
      @(negedge clk);
      rv_p   = (q.size() > 0) && (q[0].due == cyc);
      rdat_p = rv_p ? q[0].data : m_rdata_p;
      check_val("p.ch_we", bus_p.ch_we, m_we_p);
      check_val("p.ch_re", bus_p.ch_re, m_re_p);
      check_val("p.ch_addr", bus_p.ch_addr, m_addr_p);
      check_val("p.ch_wdata", bus_p.ch_wdata, m_wdata_p);
      check_val("p.rvalid", bus_p.host_rvalid, rv_p);
      check_val("p.rdata", bus_p.host_rdata, rdat_p);
      check_val("p.err_oob", err_oob_p, m_err);
      check_val("p.err_addr", err_addr_p, m_eaddr);
      check_val("c.ch_we", bus_c.ch_we, we ? chan_bit(a) : 3'b000);
      check_val("c.ch_re", bus_c.ch_re, rd ? chan_bit(a) : 3'b000);
      check_val("c.ch_addr", bus_c.ch_addr, a[3:0]);
      check_val("c.ch_wdata", bus_c.ch_wdata, d);
      check_val("c.rvalid", bus_c.host_rvalid, rd);
      check_val("c.rdata", bus_c.host_rdata, rd ? data_of(a) : m_rdata_c);
      check_val("c.err_oob", err_oob_c, m_err);
      check_val("c.err_addr", err_addr_c, m_eaddr);
      @(posedge clk);
      if (rv_p) begin
         m_rdata_p = q[0].data;
         void'(q.pop_front());
      end
      if (rd) begin
         q.push_back('{due: cyc + 2, data: data_of(a)});
         m_rdata_c = data_of(a);
      end
      m_we_p = we ? chan_bit(a) : 3'b000;
      m_re_p = rd ? chan_bit(a) : 3'b000;
      if (we || re) begin
         m_addr_p  = a[3:0];
         m_wdata_p = d;
      end
      if ((we || re) && !in_range(a)) begin
         m_err   = 1'b1;
         m_eaddr = a;
      end else if (clr) begin
         m_err = 1'b0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      t_addr = '0; t_wdata = '0; t_we = 1'b0; t_re = 1'b0; t_clr = 1'b0;
      model_reset();
      cyc = 0;
      #3;
      check_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Write into channel 1.
      run_cycle(8'h15, 32'h12345678, 1'b1, 1'b0, 1'b0);
      check_val("t1 ch_we", bus_p.ch_we, 3'b010);
      check_val("t1 ch_addr", bus_p.ch_addr, 4'h5);
      check_val("t1 ch_wdata", bus_p.ch_wdata, 32'h12345678);
      idle(2);

      // Read channel 2.
      run_cycle(8'h2A, 32'h0, 1'b0, 1'b1, 1'b0);
      check_val("t2 ch_re", bus_p.ch_re, 3'b100);
      check_val("t2 c.rvalid", bus_c.host_rvalid, 1'b1);
      check_val("t2 c.rdata", bus_c.host_rdata, 32'hC0DE0002);
      idle(1);
      check_val("t2 rvalid", bus_p.host_rvalid, 1'b1);
      check_val("t2 rdata", bus_p.host_rdata, 32'hC0DE0002);
      idle(2);

      // Out-of-range read, sticky flag, clear, and set-wins-over-clear.
      run_cycle(8'h30, 32'h0, 1'b0, 1'b1, 1'b0);
      check_val("t3 ch_re", bus_p.ch_re, 3'b000);
      check_val("t3 err_oob", err_oob_p, 1'b1);
      check_val("t3 err_addr", err_addr_p, 8'h30);
      idle(1);
      check_val("t3 rdata", bus_p.host_rdata, 32'hDEADBEEF);
      run_cycle(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
      check_val("t3 clr err_oob", err_oob_p, 1'b0);
      check_val("t3 clr err_addr", err_addr_p, 8'h30);
      run_cycle(8'h85, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
      check_val("t3 set err_oob", err_oob_p, 1'b1);
      check_val("t3 set err_addr", err_addr_p, 8'h85);
      run_cycle(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(1);

      // Back-to-back reads return in order.
      run_cycle(8'h01, 32'h0, 1'b0, 1'b1, 1'b0);
      run_cycle(8'h12, 32'h0, 1'b0, 1'b1, 1'b0);
      run_cycle(8'h23, 32'h0, 1'b0, 1'b1, 1'b0);
      check_val("t4 rdata0", bus_p.host_rdata, 32'hC0DE0001);
      idle(3);

      // Write/read collision is a write only.
      run_cycle(8'h11, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
      check_val("t5 ch_we", bus_p.ch_we, 3'b010);
      check_val("t5 ch_re", bus_p.ch_re, 3'b000);
      idle(3);

      // Asynchronous reset with a read in flight.
      run_cycle(8'h2A, 32'h0, 1'b0, 1'b1, 1'b0);
      t_re = 1'b0; t_addr = '0;
      #2 rst_n = 1'b0;
      #1 check_zero("t6 async");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      idle(4);

      for (int i = 0; i < 400; i++) begin
         logic [7:0] a;
         int         op;
         a  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 47)) : 8'($urandom_range(0, 255));
         op = $urandom_range(0, 9);
         run_cycle(a, $urandom, (op < 3) || (op == 9), (op >= 3 && op < 7) || (op == 9),
                   ($urandom_range(0, 7) == 0));
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
